// File: rtl/sum_accumulator_pkg.sv
// Shared constants and state encoding for the sum accumulator and its
// saturating adder.
package sum_accumulator_pkg;

  localparam int SUM_W         = 5;
  localparam int DEF_N_SAMPLES = 8;
  localparam int DEF_ACC_W     = 9;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/sum_accumulator_sat_add.sv
// Combinational saturating add of a 5-bit sum onto an ACC_W-bit accumulator.
// ovf flags that the true sum did not fit and the result is clamped to all ones.
module sat_add
  import sum_accumulator_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0] a,
  input  logic [SUM_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] wide;

  // One extra bit catches the carry; ACC_W >= SUM_W so the pad width is >= 1.
  assign wide = {1'b0, a} + {{(ACC_W + 1 - SUM_W){1'b0}}, b};
  assign ovf  = wide[ACC_W];
  assign sum  = ovf ? {ACC_W{1'b1}} : wide[ACC_W-1:0];

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates N_SAMPLES upstream sums into one saturating total, then holds
// the result until downstream takes it.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int N_SAMPLES = DEF_N_SAMPLES,
  parameter int ACC_W     = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [4:0]       in_sum,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; ready depends only on state, never on the partner's valid.

  localparam int                CNT_W = $clog2(N_SAMPLES);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(N_SAMPLES - 1);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             ovf, ovf_nxt;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;

  sat_add #(
    .ACC_W(ACC_W)
  ) u_sat_add (
    .a  (acc),
    .b  (in_sum),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      ovf   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    ovf_nxt   = ovf;
    case (state)
      ACCUM: begin
        if (in_valid) begin
          acc_nxt = add_sum;
          ovf_nxt = ovf | add_ovf;
          if (count == LAST) begin
            count_nxt = '0;
            state_nxt = HOLD;
          end else begin
            count_nxt = count + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_nxt   = '0;
          count_nxt = '0;
          ovf_nxt   = 1'b0;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
    // Abort wins over any accept or result handshake in the same cycle.
    if (clr) begin
      acc_nxt   = '0;
      count_nxt = '0;
      ovf_nxt   = 1'b0;
      state_nxt = ACCUM;
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign out_total = acc;
  assign out_ovf   = ovf;
  assign state_dbg = state;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed and randomized checks for sum_accumulator at default parameters
// and at N_SAMPLES=4, ACC_W=6.
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a_clr = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [4:0] a_in_sum = '0;
  logic       a_in_ready, a_out_valid, a_out_ovf, a_state;
  logic [8:0] a_out_total;

  logic       b_clr = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [4:0] b_in_sum = '0;
  logic       b_in_ready, b_out_valid, b_out_ovf, b_state;
  logic [5:0] b_out_total;

  int checks = 0;
  int errors = 0;
  bit stuck  = 0;
  int got    = 0;
  logic [6:0] exp_q[$];

  typedef struct {
    logic [4:0] s [8];
    int         exp_total;
    logic       exp_ovf;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  sum_accumulator dut_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .in_sum(a_in_sum), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_total(a_out_total), .out_ovf(a_out_ovf),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .state_dbg(a_state)
  );

  sum_accumulator #(.N_SAMPLES(4), .ACC_W(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .in_sum(b_in_sum), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_total(b_out_total), .out_ovf(b_out_ovf),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .state_dbg(b_state)
  );

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [4:0] v);
    int n;
    n = 0;
    a_in_valid = 1'b1;
    a_in_sum   = v;
    while (!a_in_ready && !stuck && n < 100) begin
      tick();
      n++;
    end
    if (!a_in_ready && !stuck) begin
      stuck = 1;
      chk("a_accept_timeout", 0, 1);
    end
    tick();
  endtask

  task automatic send_b(input logic [4:0] v);
    int n;
    n = 0;
    b_in_valid = 1'b1;
    b_in_sum   = v;
    while (!b_in_ready && !stuck && n < 100) begin
      tick();
      n++;
    end
    if (!b_in_ready && !stuck) begin
      stuck = 1;
      chk("b_accept_timeout", 0, 1);
    end
    tick();
  endtask

  // Stream one table vector back-to-back with out_ready held high.
  task automatic run_vec(input int k);
    a_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_a(vecs[k].s[i]);
    a_in_valid = 1'b0;
    chk($sformatf("vec%0d_out_valid", k), a_out_valid, 1);
    chk($sformatf("vec%0d_total", k), a_out_total, vecs[k].exp_total);
    chk($sformatf("vec%0d_ovf", k), a_out_ovf, vecs[k].exp_ovf);
    chk($sformatf("vec%0d_in_ready_hold", k), a_in_ready, 0);
    tick();
    chk($sformatf("vec%0d_in_ready_after", k), a_in_ready, 1);
    chk($sformatf("vec%0d_cleared", k), a_out_total, 0);
  endtask

  task automatic b_batch(input logic [4:0] s0, s1, s2, s3, input int et, input logic eo,
                         input string name);
    b_out_ready = 1'b1;
    send_b(s0); send_b(s1); send_b(s2); send_b(s3);
    b_in_valid = 1'b0;
    chk({name, "_valid"}, b_out_valid, 1);
    chk({name, "_total"}, b_out_total, et);
    chk({name, "_ovf"}, b_out_ovf, eo);
    tick();
    chk({name, "_clr_total"}, b_out_total, 0);
    chk({name, "_clr_ovf"}, b_out_ovf, 0);
    chk({name, "_in_ready"}, b_in_ready, 1);
  endtask

  initial begin
    vecs[0].s = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
    vecs[0].exp_total = 36;  vecs[0].exp_ovf = 1'b0;
    vecs[1].s = '{5'd30, 5'd30, 5'd30, 5'd30, 5'd30, 5'd30, 5'd30, 5'd30};
    vecs[1].exp_total = 240; vecs[1].exp_ovf = 1'b0;
    vecs[2].s = '{5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31};
    vecs[2].exp_total = 248; vecs[2].exp_ovf = 1'b0;
    vecs[3].s = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    vecs[3].exp_total = 0;   vecs[3].exp_ovf = 1'b0;
    vecs[4].s = '{5'd5, 5'd0, 5'd17, 5'd3, 5'd9, 5'd12, 5'd1, 5'd30};
    vecs[4].exp_total = 77;  vecs[4].exp_ovf = 1'b0;
    vecs[5].s = '{5'd16, 5'd16, 5'd16, 5'd16, 5'd16, 5'd16, 5'd16, 5'd16};
    vecs[5].exp_total = 128; vecs[5].exp_ovf = 1'b0;

    // Reset values while rst_n is low.
    #12;
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_total", a_out_total, 0);
    chk("rst_out_ovf", a_out_ovf, 0);

    // First edge after release already accepts.
    @(negedge clk);
    rst_n = 1'b1;
    a_in_valid = 1'b1;
    a_in_sum = 5'd9;
    tick();
    a_in_valid = 1'b0;
    chk("first_accept_total", a_out_total, 9);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("clr_idle_total", a_out_total, 0);

    for (int k = 0; k < 6; k++) run_vec(k);

    // Result held while downstream stalls; input pulses ignored.
    a_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_a(5'd30);
    for (int c = 0; c < 10; c++) begin
      chk("hold_valid", a_out_valid, 1);
      chk("hold_total", a_out_total, 240);
      chk("hold_in_ready", a_in_ready, 0);
      a_in_valid = c[0];
      a_in_sum = 5'd31;
      tick();
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    chk("hold_still_valid", a_out_valid, 1);
    tick();
    chk("hold_release_total", a_out_total, 0);
    chk("hold_release_ready", a_in_ready, 1);
    run_vec(0);

    // clr mid-batch discards the sample presented with it.
    for (int i = 0; i < 5; i++) send_a(5'd3);
    a_clr = 1'b1;
    a_in_valid = 1'b1;
    a_in_sum = 5'd7;
    tick();
    a_clr = 1'b0;
    a_in_valid = 1'b0;
    chk("clr_mid_total", a_out_total, 0);
    chk("clr_mid_ready", a_in_ready, 1);
    for (int i = 0; i < 8; i++) send_a(5'd2);
    a_in_valid = 1'b0;
    chk("clr_next_valid", a_out_valid, 1);
    chk("clr_next_total", a_out_total, 16);
    tick();

    // clr in HOLD with downstream stalled.
    a_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_a(5'd1);
    a_in_valid = 1'b0;
    chk("clr_hold_pre", a_out_valid, 1);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("clr_hold_valid", a_out_valid, 0);
    chk("clr_hold_total", a_out_total, 0);

    // Asynchronous reset mid-batch.
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_a(5'd31);
    a_in_valid = 1'b0;
    chk("pre_rst_total", a_out_total, 93);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_total", a_out_total, 0);
    chk("rst_mid_ready", a_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Asynchronous reset in HOLD.
    a_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_a(5'd31);
    a_in_valid = 1'b0;
    chk("pre_rst_hold_valid", a_out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", a_out_valid, 0);
    chk("rst_hold_total", a_out_total, 0);
    chk("rst_hold_ready", a_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_vec(2);

    // Small configuration: saturation and its boundaries.
    b_batch(5'd30, 5'd30, 5'd30, 5'd5, 63, 1'b1, "b_sat");
    b_batch(5'd1, 5'd1, 5'd1, 5'd1, 4, 1'b0, "b_after_sat");
    b_batch(5'd31, 5'd31, 5'd1, 5'd0, 63, 1'b0, "b_exact_max");
    b_batch(5'd31, 5'd31, 5'd1, 5'd1, 63, 1'b1, "b_one_over");
    b_batch(5'd31, 5'd31, 5'd0, 5'd0, 62, 1'b0, "b_below_max");

    // Random gaps on both sides, 1000 batches against a saturating sum model.
    b_out_ready = 1'b0;
    fork
      begin
        for (int bt = 0; bt < 1000; bt++) begin
          int tot;
          tot = 0;
          for (int k = 0; k < 4; k++) begin
            logic [4:0] v;
            int g;
            g = $urandom_range(0, 2);
            b_in_valid = 1'b0;
            repeat (g) tick();
            v = 5'($urandom_range(0, 31));
            tot += v;
            send_b(v);
          end
          b_in_valid = 1'b0;
          exp_q.push_back({(tot > 63) ? 1'b1 : 1'b0, (tot > 63) ? 6'd63 : 6'(tot)});
        end
      end
      begin
        int cyc;
        logic r;
        logic [6:0] e;
        cyc = 0;
        while (got < 1000 && cyc < 60000) begin
          @(posedge clk);
          #2;
          cyc++;
          r = 1'($urandom_range(0, 1));
          b_out_ready = r;
          if (b_out_valid && r) begin
            if (exp_q.size() == 0) begin
              chk("rand_unexpected_result", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk("rand_total", b_out_total, e[5:0]);
              chk("rand_ovf", b_out_ovf, e[6]);
            end
            got++;
          end
        end
      end
    join
    tick();
    b_out_ready = 1'b0;
    chk("rand_batches", got, 1000);
    chk("rand_leftover", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 8, number of 5-bit sums per result (legal range 2..16).
REQ-002 SHALL have parameter ACC_W, default 9, accumulator/result width (legal range 5..16).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port clr  input  1  synchronous abort/clear.
REQ-006 SHALL have port in_sum  input  5  sum from upstream 4-bit adder (carry-out in bit 4).
REQ-007 SHALL have port in_valid  input  1  in_sum valid.
REQ-008 SHALL have port in_ready  output  1  block accepts in_sum this cycle.
REQ-009 SHALL have port out_total  output  ACC_W  accumulated total.
REQ-010 SHALL have port out_ovf  output  1  total saturated during this batch.
REQ-011 SHALL have port out_valid  output  1  out_total/out_ovf valid.
REQ-012 SHALL have port out_ready  input  1  downstream consumes result.

Function
REQ-013 SHALL implement two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-014 Accept SHALL occur on any cycle with in_valid=1 and in_ready=1; no accept otherwise.
REQ-015 On accept, acc SHALL become acc+in_sum (zero-extended), and count SHALL increment.
REQ-016 If acc+in_sum exceeds 2^ACC_W-1, acc SHALL saturate at 2^ACC_W-1 and ovf SHALL set (sticky until batch end).
REQ-017 Accept with count=N_SAMPLES-1 SHALL move ACCUM->HOLD; out_valid SHALL be 1 the next cycle (latency 1 from last accept).
REQ-018 out_total SHALL equal acc and out_ovf SHALL equal ovf at all times; both stable throughout HOLD.
REQ-019 In HOLD, out_valid&out_ready SHALL clear acc, count and ovf and return to ACCUM; in_ready=1 the following cycle.
REQ-020 In HOLD with out_ready=0, the block SHALL hold indefinitely; in_sum/in_valid ignored.
REQ-021 clr=1 SHALL, regardless of state or concurrent handshakes, clear acc, count, ovf and enter ACCUM next cycle; the coinciding input accept and output handshake SHALL be discarded.
REQ-022 All 32 in_sum values SHALL be accepted unchecked (values above 30 are not errors).
REQ-023 in_valid deasserting mid-batch SHALL stall count; no timeout.

Reset
REQ-024 rst_n=0 SHALL immediately force state ACCUM, acc=0, count=0, ovf=0.
REQ-025 Reset values: in_ready=1, out_valid=0, out_total=0, out_ovf=0; reset mid-batch or in HOLD discards the batch.
REQ-026 First accept SHALL be possible on the first rising clk edge after rst_n deasserts.

Structure
REQ-027 Shared package SHALL hold SUM_W=5, the ACCUM/HOLD state encoding, and the default N_SAMPLES/ACC_W constants.
REQ-028 Saturating add SHALL be a sub-module sat_add (ACC_W-bit + SUM_W-bit -> ACC_W-bit result plus overflow flag), combinational.
REQ-029 count SHALL be sized clog2(N_SAMPLES) bits; no other storage beyond acc, ovf, state.

Verification
REQ-030 Defaults, sums 1..8 streamed back-to-back, out_ready=1 -> out_valid one cycle after 8th accept, out_total=36, out_ovf=0, in_ready=1 next cycle.
REQ-031 N_SAMPLES=4, ACC_W=6, sums 30,30,30,5 -> out_total=63, out_ovf=1; next batch 1,1,1,1 -> out_total=4, out_ovf=0.
REQ-032 Defaults, batch of eight 30s, out_ready=0 for 10 cycles -> out_valid held 10 cycles, out_total=240, in_ready=0, extra in_valid pulses ignored.
REQ-033 Defaults, 5 sums accepted then clr=1 with in_valid=1 -> sum in clr cycle discarded; next 8 sums of 2 -> out_total=16.
REQ-034 rst_n pulsed low mid-batch (3 accepted) and separately in HOLD -> outputs immediately at reset values; next full batch of 31s -> out_total=248.
REQ-035 Random in_valid/out_ready gaps, 1000 batches -> every out_total equals reference model sum (saturated), no lost or duplicated samples.
